// File: rtl/bus_select_arbiter.sv
// Registered bus-source arbiter. Turns N "drive bus" out-strobes into a bus-mux select.
// It supports fixed-priority or round-robin selection, grant lock, and a multi-driver debug counter.
module bus_select_arbiter #(
  parameter int N    = 24,
  parameter int SW   = 5,
  parameter int MODE = 0,
  parameter int CW   = 8
) (
  input  logic          clock,
  input  logic          clear_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic          lock,
  input  logic          cnt_clr,
  output logic [SW-1:0] sel,
  output logic          sel_valid,
  output logic          multi_hit,
  output logic [CW-1:0] conflict_cnt
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] win;
  logic [SW:0]   idx;
  logic          any_req;
  logic          nxt_multi;
  logic          req_at_sel;
  logic          hold;

  always_comb begin
    any_req    = |req;
    // clearing the lowest set bit leaves something only when two or more bits were set
    nxt_multi  = |(req & (req - N'(1)));
    req_at_sel = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) req_at_sel = req[i];
    end
    hold = lock & sel_valid & req_at_sel;

    win = '0;
    idx = '0;
    if (MODE == 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) win = SW'(i);
      end
    end else begin
      // scan offsets high to low so the nearest requester after ptr is written last
      for (int off = N; off >= 1; off--) begin
        idx = {1'b0, ptr} + (SW+1)'(off);
        if (idx >= (SW+1)'(N)) idx = idx - (SW+1)'(N);
        if (req[idx[SW-1:0]]) win = idx[SW-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      sel       <= '0;
      sel_valid <= 1'b0;
      ptr       <= SW'(N - 1);
    end else if (en && !hold) begin
      if (any_req) begin
        sel       <= win;
        sel_valid <= 1'b1;
        ptr       <= win;
      end else begin
        sel_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      multi_hit    <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      multi_hit <= nxt_multi;
      if (cnt_clr) begin
        conflict_cnt <= '0;
      end else if (nxt_multi && (conflict_cnt != {CW{1'b1}})) begin
        conflict_cnt <= conflict_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Bench for bus_select_arbiter: a fixed-priority and a round-robin instance share stimulus.
// Expected outputs are queued per step and compared once the DUT has registered them.
module tb_bus_select_arbiter;

  typedef struct packed {
    logic [4:0] sel;
    logic       valid;
    logic       mh;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic [23:0] req;
    logic        lock;
    logic        en;
    logic        clr;
    logic        rst;
    exp_t        e;
  } step_t;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        en;
  logic [23:0] req;
  logic        lock;
  logic        cnt_clr;

  logic [4:0] sel_fp, sel_rr;
  logic       valid_fp, valid_rr, mh_fp, mh_rr;
  logic [7:0] cnt_fp, cnt_rr;
  exp_t       act_fp, act_rr;

  assign act_fp = {sel_fp, valid_fp, mh_fp, cnt_fp};
  assign act_rr = {sel_rr, valid_rr, mh_rr, cnt_rr};

  exp_t q_fp[$];
  exp_t q_rr[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  bus_select_arbiter #(.N(24), .SW(5), .MODE(0), .CW(8)) dut_fp (
    .clock(clock), .clear_n(clear_n), .en(en), .req(req), .lock(lock), .cnt_clr(cnt_clr),
    .sel(sel_fp), .sel_valid(valid_fp), .multi_hit(mh_fp), .conflict_cnt(cnt_fp)
  );

  bus_select_arbiter #(.N(24), .SW(5), .MODE(1), .CW(8)) dut_rr (
    .clock(clock), .clear_n(clear_n), .en(en), .req(req), .lock(lock), .cnt_clr(cnt_clr),
    .sel(sel_rr), .sel_valid(valid_rr), .multi_hit(mh_rr), .conflict_cnt(cnt_rr)
  );

  function automatic logic [23:0] b(int i);
    return 24'(1) << i;
  endfunction

  function automatic step_t mk(logic [23:0] r, logic lk, logic e, logic c,
                               int s, logic v, logic m, int n);
    step_t t;
    t.req = r; t.lock = lk; t.en = e; t.clr = c; t.rst = 1'b0;
    t.e.sel = 5'(s); t.e.valid = v; t.e.mh = m; t.e.cnt = 8'(n);
    return t;
  endfunction

  // all waits below are fixed cycle counts; called at posedge+1
  task automatic reset_dut();
    req = '0; lock = 1'b0; en = 1'b1; cnt_clr = 1'b0;
    clear_n = 1'b0;
    #2;
    clear_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic apply(step_t s);
    req = s.req; lock = s.lock; en = s.en; cnt_clr = s.clr;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    step_t st[$];
    exp_t  e;
    reset_dut();
    st.push_back(mk(b(5) | b(20), 0, 1, 0, 5, 1, 1, 1));
    st.push_back(mk('0, 0, 1, 0, 5, 0, 0, 1));
    foreach (st[i]) begin
      q_fp.push_back(st[i].e);
      apply(st[i]);
      e = q_fp.pop_front();
      checks++;
      if (act_fp !== e) begin
        errors++;
        $display("FAIL reset_pre[%0d] got sel=%0d valid=%0b mh=%0b cnt=%0d want sel=%0d valid=%0b mh=%0b cnt=%0d",
                 i, act_fp.sel, act_fp.valid, act_fp.mh, act_fp.cnt, e.sel, e.valid, e.mh, e.cnt);
      end
    end
    q_fp.push_back('0);
    q_rr.push_back('0);
    clear_n = 1'b0;
    #1;
    e = q_fp.pop_front();
    checks++;
    if (act_fp !== e) begin
      errors++;
      $display("FAIL reset_async_fp got sel=%0d valid=%0b mh=%0b cnt=%0d want all zero",
               act_fp.sel, act_fp.valid, act_fp.mh, act_fp.cnt);
    end
    e = q_rr.pop_front();
    checks++;
    if (act_rr !== e) begin
      errors++;
      $display("FAIL reset_async_rr got sel=%0d valid=%0b mh=%0b cnt=%0d want all zero",
               act_rr.sel, act_rr.valid, act_rr.mh, act_rr.cnt);
    end
    #1;
    clear_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      q_fp.push_back('0);
      apply(mk('0, 0, 1, 0, 0, 0, 0, 0));
      e = q_fp.pop_front();
      checks++;
      if (act_fp !== e) begin
        errors++;
        $display("FAIL reset_idle[%0d] got sel=%0d valid=%0b mh=%0b cnt=%0d want all zero",
                 k, act_fp.sel, act_fp.valid, act_fp.mh, act_fp.cnt);
      end
    end
  endtask

  task automatic test_fixed_priority();
    step_t st[$];
    exp_t  e;
    reset_dut();
    st.push_back(mk(b(20), 0, 1, 0, 20, 1, 0, 0));
    st.push_back(mk(b(5) | b(21), 0, 1, 0, 5, 1, 1, 1));
    st.push_back(mk(b(23), 0, 1, 0, 23, 1, 0, 1));
    st.push_back(mk(b(0) | b(12) | b(23), 0, 1, 0, 0, 1, 1, 2));
    st.push_back(mk(b(12), 0, 1, 0, 12, 1, 0, 2));
    st.push_back(mk('0, 0, 1, 0, 12, 0, 0, 2));
    foreach (st[i]) begin
      q_fp.push_back(st[i].e);
      apply(st[i]);
      e = q_fp.pop_front();
      checks++;
      if (act_fp !== e) begin
        errors++;
        $display("FAIL fixed_priority[%0d] got sel=%0d valid=%0b mh=%0b cnt=%0d want sel=%0d valid=%0b mh=%0b cnt=%0d",
                 i, act_fp.sel, act_fp.valid, act_fp.mh, act_fp.cnt, e.sel, e.valid, e.mh, e.cnt);
      end
    end
  endtask

  task automatic test_round_robin();
    step_t st[$];
    exp_t  e;
    reset_dut();
    st.push_back(mk(b(3) | b(7) | b(23), 0, 1, 0, 3, 1, 1, 1));
    st.push_back(mk(b(3) | b(7) | b(23), 0, 1, 0, 7, 1, 1, 2));
    st.push_back(mk(b(3) | b(7) | b(23), 0, 1, 0, 23, 1, 1, 3));
    st.push_back(mk(b(3) | b(7) | b(23), 0, 1, 0, 3, 1, 1, 4));
    st.push_back(mk('0, 0, 1, 0, 3, 0, 0, 4));
    st.push_back(mk(b(3), 0, 1, 0, 3, 1, 0, 4));
    st.push_back(mk(b(3) | b(5), 0, 1, 0, 5, 1, 1, 5));
    st.push_back(mk(b(0) | b(5), 0, 1, 0, 0, 1, 1, 6));
    foreach (st[i]) begin
      q_rr.push_back(st[i].e);
      apply(st[i]);
      e = q_rr.pop_front();
      checks++;
      if (act_rr !== e) begin
        errors++;
        $display("FAIL round_robin[%0d] got sel=%0d valid=%0b mh=%0b cnt=%0d want sel=%0d valid=%0b mh=%0b cnt=%0d",
                 i, act_rr.sel, act_rr.valid, act_rr.mh, act_rr.cnt, e.sel, e.valid, e.mh, e.cnt);
      end
    end
  endtask

  task automatic test_lock();
    step_t st[$];
    step_t s;
    exp_t  e;
    reset_dut();
    st.push_back(mk(b(21), 1, 1, 0, 21, 1, 0, 0));
    st.push_back(mk(b(21) | b(2), 1, 1, 0, 21, 1, 1, 1));
    st.push_back(mk(b(21) | b(2), 1, 1, 0, 21, 1, 1, 2));
    st.push_back(mk(b(21) | b(2), 1, 1, 0, 21, 1, 1, 3));
    st.push_back(mk(b(2), 1, 1, 0, 2, 1, 0, 3));
    st.push_back(mk(b(21), 1, 1, 0, 21, 1, 0, 3));
    st.push_back(mk(b(21) | b(2), 1, 1, 0, 21, 1, 1, 4));
    s = mk(b(21) | b(2), 1, 1, 0, 2, 1, 1, 1);
    s.rst = 1'b1;
    st.push_back(s);
    foreach (st[i]) begin
      if (st[i].rst) reset_dut();
      q_fp.push_back(st[i].e);
      apply(st[i]);
      e = q_fp.pop_front();
      checks++;
      if (act_fp !== e) begin
        errors++;
        $display("FAIL lock[%0d] got sel=%0d valid=%0b mh=%0b cnt=%0d want sel=%0d valid=%0b mh=%0b cnt=%0d",
                 i, act_fp.sel, act_fp.valid, act_fp.mh, act_fp.cnt, e.sel, e.valid, e.mh, e.cnt);
      end
    end
  endtask

  task automatic test_saturation();
    step_t st[$];
    exp_t  e;
    reset_dut();
    for (int k = 0; k < 300; k++)
      st.push_back(mk(b(0) | b(1), 0, 1, 0, 0, 1, 1, (k < 255) ? k + 1 : 255));
    st.push_back(mk(b(0) | b(1), 0, 1, 1, 0, 1, 1, 0));
    st.push_back(mk(b(0) | b(1), 0, 1, 0, 0, 1, 1, 1));
    foreach (st[i]) begin
      q_fp.push_back(st[i].e);
      apply(st[i]);
      e = q_fp.pop_front();
      checks++;
      if (act_fp !== e) begin
        errors++;
        $display("FAIL saturation[%0d] got sel=%0d valid=%0b mh=%0b cnt=%0d want sel=%0d valid=%0b mh=%0b cnt=%0d",
                 i, act_fp.sel, act_fp.valid, act_fp.mh, act_fp.cnt, e.sel, e.valid, e.mh, e.cnt);
      end
    end
  endtask

  task automatic test_enable();
    step_t st[$];
    exp_t  e;
    reset_dut();
    st.push_back(mk(b(4), 0, 1, 0, 4, 1, 0, 0));
    st.push_back(mk(b(9), 0, 0, 0, 4, 1, 0, 0));
    st.push_back(mk(b(9), 0, 0, 0, 4, 1, 0, 0));
    st.push_back(mk(b(9) | b(10), 0, 0, 0, 4, 1, 1, 1));
    st.push_back(mk(b(9), 0, 1, 0, 9, 1, 0, 1));
    st.push_back(mk('0, 0, 0, 0, 9, 1, 0, 1));
    foreach (st[i]) begin
      q_fp.push_back(st[i].e);
      apply(st[i]);
      e = q_fp.pop_front();
      checks++;
      if (act_fp !== e) begin
        errors++;
        $display("FAIL enable[%0d] got sel=%0d valid=%0b mh=%0b cnt=%0d want sel=%0d valid=%0b mh=%0b cnt=%0d",
                 i, act_fp.sel, act_fp.valid, act_fp.mh, act_fp.cnt, e.sel, e.valid, e.mh, e.cnt);
      end
    end
  endtask

  task automatic test_rr_enable();
    step_t st[$];
    exp_t  e;
    reset_dut();
    st.push_back(mk(b(3) | b(7), 0, 1, 0, 3, 1, 1, 1));
    st.push_back(mk(b(3) | b(7), 0, 0, 0, 3, 1, 1, 2));
    st.push_back(mk(b(3) | b(7), 0, 0, 0, 3, 1, 1, 3));
    st.push_back(mk(b(3) | b(7), 0, 1, 0, 7, 1, 1, 4));
    st.push_back(mk(b(3) | b(7), 0, 1, 0, 3, 1, 1, 5));
    foreach (st[i]) begin
      q_rr.push_back(st[i].e);
      apply(st[i]);
      e = q_rr.pop_front();
      checks++;
      if (act_rr !== e) begin
        errors++;
        $display("FAIL rr_enable[%0d] got sel=%0d valid=%0b mh=%0b cnt=%0d want sel=%0d valid=%0b mh=%0b cnt=%0d",
                 i, act_rr.sel, act_rr.valid, act_rr.mh, act_rr.cnt, e.sel, e.valid, e.mh, e.cnt);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_n = 1'b0; en = 1'b1; req = '0; lock = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    clear_n = 1'b1;
    @(posedge clock); #1;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_lock();
    test_saturation();
    test_enable();
    test_rr_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_select_arbiter.md
Name: bus_select_arbiter

Overview:
- Parametrised, registered successor to the datapath bus-source encoder.
- Takes N one-hot "drive bus" requests (register outs, HI/LO, Zhigh/Zlow, PC, MDR, In.Port, C, plus future sources) and produces a registered bus-mux select with a valid flag.
- Supports fixed-priority or round-robin selection, grant locking for multi-cycle transfers, and multi-driver conflict detection with a saturating conflict counter for debug.
- Sits between control-unit out-strobes and the 32:1 bus multiplexer.

Parameters:
N, 24, number of request inputs (2..32)
SW, 5, select width; must satisfy 2^SW >= N
MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
CW, 8, conflict counter width

Ports:
clock  in  1  rising-edge clock
clear_n  in  1  asynchronous active-low reset
en  in  1  advance enable; when 0, the select/valid/pointer state holds
req  in  N  bus-drive requests; bit i = source i (encoding as bus mux: 0..15 R0..R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 In.Port, 23 C)
lock  in  1  hold current grant while its request stays asserted
cnt_clr  in  1  synchronous clear of conflict counter
sel  out  SW  registered bus-mux select
sel_valid  out  1  registered; 1 = sel names an actively requesting source
multi_hit  out  1  registered; 1 = more than one req bit set in previous cycle
conflict_cnt  out  CW  saturating count of multi-hit cycles

Behaviour:
- Reset (clear_n=0, asynchronous): sel=0, sel_valid=0, multi_hit=0, conflict_cnt=0, rr pointer=N-1 (first round-robin search starts at index 0). Reset mid-transfer drops the lock immediately.
- All outputs are registered. Latency: req sampled at edge k appears on sel/sel_valid after edge k, i.e. one cycle.
- Winner computation on each edge with en=1:
  - lock=1, sel_valid=1 and req[sel]=1: sel held, sel_valid=1, pointer unchanged.
  - Otherwise, if any req is set: MODE 0 picks the lowest set index. MODE 1 searches from pointer+1 upward, wrapping N-1 to 0, and picks the first set bit. sel <= winner, sel_valid <= 1, pointer <= winner.
  - No req set: sel holds its last value (no implicit change to 0), sel_valid <= 0, pointer unchanged.
  - lock=1 while the locked source's req drops: the lock is released that edge and normal selection applies in the same edge.
- en=0: sel, sel_valid and pointer hold. multi_hit and conflict_cnt still update.
- multi_hit <= (popcount(req) > 1) every edge, independent of en and lock.
- conflict_cnt:
  - Increments by 1 on each edge where popcount(req) > 1.
  - Saturates at 2^CW-1 with no wrap.
  - cnt_clr=1 forces 0 and wins over a simultaneous increment.
- req bits at indices >= N do not exist. sel never exceeds N-1.
- Wrap boundary, MODE 1: with pointer=N-1, the search order is 0,1,…,N-1. With pointer=k, index k is checked last, so the same source is re-granted only if it is the sole requester.
- No combinational path from req to any output.

Test Plan:
- Reset then idle: clear_n pulse low mid-cycle with req=0 -> all outputs 0 immediately. After release, sel=0, sel_valid=0 for 5 cycles.
- Fixed priority, MODE=0: req bit 20 (PC) alone -> next cycle sel=20, sel_valid=1. Then req bits 5 and 21 -> sel=5, multi_hit=1, conflict_cnt=1.
- Round-robin, MODE=1: req bits 3, 7 and 23 held for 4 cycles -> sel sequence 3, 7, 23, 3, with conflict_cnt=4. Then req=0 -> sel stays 3, sel_valid=0.
- Lock: grant sel=21 with lock=1, then add req bit 2 -> sel stays 21 for 3 cycles. Drop req bit 21 -> next cycle sel=2, sel_valid=1.
- Saturation with CW=8: hold req bits 0 and 1 for 300 cycles -> conflict_cnt=255. Assert cnt_clr with the conflict still present -> conflict_cnt=0.
- en=0: grant sel=4, deassert en, change req to bit 9 -> sel stays 4 and sel_valid stays 1. Re-assert en -> next cycle sel=9.
